// File: rtl/fence_sequencer_pkg.sv
// Shared types for the fence sequencer: latched operation and FSM state encodings.
package fence_sequencer_pkg;

  typedef enum logic [1:0] {
    FSEQ_NONE    = 2'd0,
    FSEQ_FENCE   = 2'd1,
    FSEQ_FENCE_I = 2'd2,
    FSEQ_SFENCE  = 2'd3
  } fseq_op_e;

  typedef enum logic [2:0] {
    FSEQ_IDLE,
    FSEQ_DRAIN,
    FSEQ_DFLUSH,
    FSEQ_IFLUSH,
    FSEQ_TLBFL,
    FSEQ_RESUME
  } fseq_state_e;

  // FENCE.I outranks SFENCE.VMA, which outranks FENCE.
  function automatic fseq_op_e fseq_pick_op(logic fence, logic fence_i, logic sfence);
    if (fence_i)     return FSEQ_FENCE_I;
    else if (sfence) return FSEQ_SFENCE;
    else if (fence)  return FSEQ_FENCE;
    else             return FSEQ_NONE;
  endfunction

endpackage

// File: rtl/fence_sequencer_if.sv
// Request/action bundle between commit_stage, caches/MMU and the fence sequencer.
interface fence_sequencer_if;

  logic halt_i;
  logic fence_req_i;
  logic fence_i_req_i;
  logic sfence_vma_req_i;
  logic no_st_pending_i;
  logic dcache_flush_ack_i;
  logic dcache_flush_o;
  logic icache_flush_o;
  logic tlb_flush_o;
  logic flush_pipeline_o;
  logic done_o;
  logic busy_o;
  logic timeout_o;
  fence_sequencer_pkg::fseq_op_e op_o;

  modport master (
    output halt_i, fence_req_i, fence_i_req_i, sfence_vma_req_i,
           no_st_pending_i, dcache_flush_ack_i,
    input  dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o,
           done_o, busy_o, timeout_o, op_o
  );

  modport slave (
    input  halt_i, fence_req_i, fence_i_req_i, sfence_vma_req_i,
           no_st_pending_i, dcache_flush_ack_i,
    output dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o,
           done_o, busy_o, timeout_o, op_o
  );

endinterface

// File: rtl/fence_sequencer_watchdog.sv
// Saturating wait counter; expired_o flags the last permitted waiting cycle.
module fence_sequencer_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign expired_o = (count_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fence_sequencer.sv
// Orders FENCE / FENCE.I / SFENCE.VMA: drain stores, flush D$/I$/TLB, then one pipeline-flush pulse.
module fence_sequencer
  import fence_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES        = 1024,
  parameter bit          FLUSH_DCACHE_ON_FENCE = 1'b1
) (
  input logic               clk_i,
  input logic               rst_ni,
  fence_sequencer_if.slave  fs
);

  fseq_state_e state_q, state_d;
  fseq_op_e    op_q, op_d;
  logic        timeout_q, timeout_d;
  logic        wd_expired;
  logic        any_req;

  assign any_req = fs.fence_req_i | fs.fence_i_req_i | fs.sfence_vma_req_i;

  // A completion in the expiry cycle is checked first, so it beats the watchdog.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    timeout_d = 1'b0;
    unique case (state_q)
      FSEQ_IDLE: begin
        if (!fs.halt_i && any_req) begin
          op_d    = fseq_pick_op(fs.fence_req_i, fs.fence_i_req_i, fs.sfence_vma_req_i);
          state_d = FSEQ_DRAIN;
        end
      end
      FSEQ_DRAIN: begin
        if (fs.no_st_pending_i) begin
          unique case (op_q)
            FSEQ_FENCE_I: state_d = FSEQ_DFLUSH;
            FSEQ_SFENCE:  state_d = FSEQ_TLBFL;
            default:      state_d = FLUSH_DCACHE_ON_FENCE ? FSEQ_DFLUSH : FSEQ_RESUME;
          endcase
        end else if (wd_expired) begin
          state_d   = FSEQ_IDLE;
          op_d      = FSEQ_NONE;
          timeout_d = 1'b1;
        end
      end
      FSEQ_DFLUSH: begin
        if (fs.dcache_flush_ack_i) begin
          state_d = (op_q == FSEQ_FENCE_I) ? FSEQ_IFLUSH : FSEQ_RESUME;
        end else if (wd_expired) begin
          state_d   = FSEQ_IDLE;
          op_d      = FSEQ_NONE;
          timeout_d = 1'b1;
        end
      end
      FSEQ_IFLUSH: state_d = FSEQ_RESUME;
      FSEQ_TLBFL:  state_d = FSEQ_RESUME;
      FSEQ_RESUME: begin
        state_d = FSEQ_IDLE;
        op_d    = FSEQ_NONE;
      end
      default: begin
        state_d = FSEQ_IDLE;
        op_d    = FSEQ_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FSEQ_IDLE;
      op_q      <= FSEQ_NONE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      timeout_q <= timeout_d;
    end
  end

  fence_sequencer_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (state_d != state_q),
    .enable_i  ((state_q == FSEQ_DRAIN) || (state_q == FSEQ_DFLUSH)),
    .expired_o (wd_expired)
  );

  // D$ request drops in the ack cycle itself; the state follows on the next edge.
  assign fs.dcache_flush_o   = (state_q == FSEQ_DFLUSH) && !fs.dcache_flush_ack_i;
  assign fs.icache_flush_o   = (state_q == FSEQ_IFLUSH);
  assign fs.tlb_flush_o      = (state_q == FSEQ_TLBFL);
  assign fs.flush_pipeline_o = (state_q == FSEQ_RESUME);
  assign fs.done_o           = (state_q == FSEQ_RESUME);
  assign fs.busy_o           = (state_q != FSEQ_IDLE);
  assign fs.timeout_o        = timeout_q;
  assign fs.op_o             = op_q;

endmodule

// File: tb/tb_fence_sequencer.sv
// Directed, table-driven bench for fence_sequencer (TIMEOUT_CYCLES=8 instance plus a no-D$-flush instance).
module tb_fence_sequencer;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  fence_sequencer_if ifa ();
  fence_sequencer_if ifb ();

  assign ifb.halt_i             = ifa.halt_i;
  assign ifb.fence_req_i        = ifa.fence_req_i;
  assign ifb.fence_i_req_i      = ifa.fence_i_req_i;
  assign ifb.sfence_vma_req_i   = ifa.sfence_vma_req_i;
  assign ifb.no_st_pending_i    = ifa.no_st_pending_i;
  assign ifb.dcache_flush_ack_i = ifa.dcache_flush_ack_i;

  fence_sequencer #(
    .TIMEOUT_CYCLES        (8),
    .FLUSH_DCACHE_ON_FENCE (1'b1)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .fs     (ifa)
  );

  fence_sequencer #(
    .TIMEOUT_CYCLES        (1024),
    .FLUSH_DCACHE_ON_FENCE (1'b0)
  ) dut_nf (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .fs     (ifb)
  );

  // inputs {halt, fence, fence_i, sfence, no_st_pending, ack}
  // outputs {dflush, iflush, tlb, flush_pipe, done, busy, timeout, op[1:0]}
  typedef struct {
    string      name;
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  localparam logic [8:0] IDLE0 = 9'b0000_0_0_0_00;

  vec_t vecs[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic logic [8:0] outs_a();
    return {ifa.dcache_flush_o, ifa.icache_flush_o, ifa.tlb_flush_o, ifa.flush_pipeline_o,
            ifa.done_o, ifa.busy_o, ifa.timeout_o, ifa.op_o};
  endfunction

  function automatic logic [8:0] outs_b();
    return {ifb.dcache_flush_o, ifb.icache_flush_o, ifb.tlb_flush_o, ifb.flush_pipeline_o,
            ifb.done_o, ifb.busy_o, ifb.timeout_o, ifb.op_o};
  endfunction

  task automatic check(input string n, input logic [8:0] got, input logic [8:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", n, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] v);
    {ifa.halt_i, ifa.fence_req_i, ifa.fence_i_req_i, ifa.sfence_vma_req_i,
     ifa.no_st_pending_i, ifa.dcache_flush_ack_i} = v;
  endtask

  // Called just after a rising edge: drive, check at the falling edge, advance one cycle.
  task automatic step_chk(input string n, input logic [5:0] v, input logic [8:0] exp, input bit on_b);
    drive(v);
    @(negedge clk);
    check(n, on_b ? outs_b() : outs_a(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic [5:0] v, input logic [8:0] e);
    vec_t r;
    r.name = n;
    r.in   = v;
    r.exp  = e;
    vecs.push_back(r);
  endtask

  initial begin
    // FENCE.I, ack on the 4th DFLUSH cycle; an ack during DRAIN is ignored
    add("fi_c0", 6'b001010, IDLE0);
    add("fi_c1", 6'b001011, 9'b0000_0_1_0_10);
    add("fi_c2", 6'b001010, 9'b1000_0_1_0_10);
    add("fi_c3", 6'b001010, 9'b1000_0_1_0_10);
    add("fi_c4", 6'b001010, 9'b1000_0_1_0_10);
    add("fi_c5", 6'b001011, 9'b0000_0_1_0_10);
    add("fi_c6", 6'b001010, 9'b0100_0_1_0_10);
    add("fi_c7", 6'b001010, 9'b0001_1_1_0_10);
    add("fi_c8", 6'b000010, IDLE0);
    add("ack_idle", 6'b000001, IDLE0);
    // SFENCE with stores pending for 4 DRAIN cycles (5 cycles in DRAIN)
    add("sf_c0", 6'b000100, IDLE0);
    add("sf_c1", 6'b000100, 9'b0000_0_1_0_11);
    add("sf_c2", 6'b000101, 9'b0000_0_1_0_11);
    add("sf_c3", 6'b000100, 9'b0000_0_1_0_11);
    add("sf_c4", 6'b000100, 9'b0000_0_1_0_11);
    add("sf_c5", 6'b000110, 9'b0000_0_1_0_11);
    add("sf_c6", 6'b000110, 9'b0010_0_1_0_11);
    add("sf_c7", 6'b000110, 9'b0001_1_1_0_11);
    add("sf_c8", 6'b000010, IDLE0);
    // FENCE + FENCE.I together, minimum latency
    add("pri_c0", 6'b011010, IDLE0);
    add("pri_c1", 6'b011010, 9'b0000_0_1_0_10);
    add("pri_c2", 6'b011011, 9'b0000_0_1_0_10);
    add("pri_c3", 6'b011010, 9'b0100_0_1_0_10);
    add("pri_c4", 6'b011010, 9'b0001_1_1_0_10);
    add("pri_c5", 6'b000010, IDLE0);
    // FENCE + SFENCE together
    add("pri2_c0", 6'b010110, IDLE0);
    add("pri2_c1", 6'b010110, 9'b0000_0_1_0_11);
    add("pri2_c2", 6'b010110, 9'b0010_0_1_0_11);
    add("pri2_c3", 6'b010110, 9'b0001_1_1_0_11);
    add("pri2_c4", 6'b000010, IDLE0);
    // halt blocks acceptance; halt raised during DFLUSH does not
    add("halt_c0", 6'b110010, IDLE0);
    add("halt_c1", 6'b110010, IDLE0);
    add("halt_c2", 6'b010010, IDLE0);
    add("halt_c3", 6'b010010, 9'b0000_0_1_0_01);
    add("halt_c4", 6'b010010, 9'b1000_0_1_0_01);
    add("halt_c5", 6'b110010, 9'b1000_0_1_0_01);
    add("halt_c6", 6'b110011, 9'b0000_0_1_0_01);
    add("halt_c7", 6'b110010, 9'b0001_1_1_0_01);
    add("halt_c8", 6'b110010, IDLE0);
    add("halt_c9", 6'b000010, IDLE0);
    // watchdog: 8 DFLUSH cycles without ack
    add("tmo_c0", 6'b001010, IDLE0);
    add("tmo_c1", 6'b001010, 9'b0000_0_1_0_10);
    for (int i = 0; i < 8; i++) add($sformatf("tmo_df%0d", i), 6'b001010, 9'b1000_0_1_0_10);
    add("tmo_pulse", 6'b000010, 9'b0000_0_0_1_00);
    add("tmo_after", 6'b000010, IDLE0);
    // ack on the expiry cycle completes normally
    add("tack_c0", 6'b001010, IDLE0);
    add("tack_c1", 6'b001010, 9'b0000_0_1_0_10);
    for (int i = 0; i < 7; i++) add($sformatf("tack_df%0d", i), 6'b001010, 9'b1000_0_1_0_10);
    add("tack_ack", 6'b001011, 9'b0000_0_1_0_10);
    add("tack_if", 6'b001010, 9'b0100_0_1_0_10);
    add("tack_done", 6'b001010, 9'b0001_1_1_0_10);
    add("tack_idle", 6'b000010, IDLE0);
    add("tack_idle2", 6'b000010, IDLE0);

    drive(6'b000000);
    #12;
    check("reset_a", outs_a(), IDLE0);
    check("reset_b", outs_b(), IDLE0);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // lone FENCE without D$ flush: DRAIN -> RESUME
    step_chk("nf_c0", 6'b010010, IDLE0, 1'b1);
    step_chk("nf_c1", 6'b010010, 9'b0000_0_1_0_01, 1'b1);
    step_chk("nf_c2", 6'b000010, 9'b0001_1_1_0_01, 1'b1);
    step_chk("nf_c3", 6'b000011, IDLE0, 1'b1);
    step_chk("nf_a4", 6'b000010, 9'b0001_1_1_0_01, 1'b0);
    step_chk("nf_a5", 6'b000010, IDLE0, 1'b0);

    foreach (vecs[i]) step_chk(vecs[i].name, vecs[i].in, vecs[i].exp, 1'b0);

    // asynchronous reset while in DFLUSH, then re-acceptance of the held request
    step_chk("rst_c0", 6'b001010, IDLE0, 1'b0);
    step_chk("rst_c1", 6'b001010, 9'b0000_0_1_0_10, 1'b0);
    drive(6'b001010);
    #2;
    check("rst_dflush", outs_a(), 9'b1000_0_1_0_10);
    rst_ni = 1'b0;
    #1;
    check("rst_async", outs_a(), IDLE0);
    @(posedge clk);
    #1;
    check("rst_held", outs_a(), IDLE0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    step_chk("rst_reacc", 6'b001010, 9'b0000_0_1_0_10, 1'b0);
    step_chk("rst_df", 6'b001011, 9'b0000_0_1_0_10, 1'b0);
    step_chk("rst_if", 6'b001010, 9'b0100_0_1_0_10, 1'b0);
    step_chk("rst_done", 6'b001010, 9'b0001_1_1_0_10, 1'b0);
    step_chk("rst_idle", 6'b000010, IDLE0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
